uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver: second-generation serial input for the design.
//  Configurable data width, parity, stop bits and baud rate; double-flop input sync; start-glitch rejection.
//  Per-word parity/framing flags; buffered output with overrun detection.
//  Feeds the host-side consumer through the Receive/Received handshake.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock in Hz
//  BAUD        19_200       line rate; BAUD_DIV = CLK_FREQ/BAUD (default 5208), HALF_DIV = BAUD_DIV/2
//  DATA_BITS   8            data bits per frame, legal 5..9, LSB first
//  PARITY      0            0 none, 1 even, 2 odd
//  STOP_BITS   1            1 or 2
//  FIFO_DEPTH  4            word buffer depth, power of 2 >= 2 (used only with RX_FIFO_EN)
// PORTS
//  clk        in   1                        system clock, all logic on posedge
//  Reset_n    in   1                        asynchronous active-low reset
//  Sin        in   1                        serial line, idle high, asynchronous to clk
//  Receive    out  1                        word available at Dout (buffer not empty)
//  Received   in   1                        consumer pop; acts only when Receive=1
//  Dout       out  DATA_BITS                head word of buffer
//  parityErr  out  1                        parity flag of head word (0 when PARITY=0)
//  frameErr   out  1                        head word had a low stop bit
//  overrun    out  1                        sticky: a completed word was dropped
//  count      out  $clog2(FIFO_DEPTH+1)     words held
// BEHAVIOUR
//  - Reset (async, Reset_n=0): FSM IDLE, timer and bit counter 0, buffer empty; Receive, Dout, parityErr, frameErr, overrun, count all 0; sync flops preset to 1.
//  - Sin passes two flops (sRx); all sampling uses sRx, 2-cycle input latency.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    IDLE: timer held 0; sRx=0 -> START.
//    START: at timer==HALF_DIV-1 sample sRx; 0 -> DATA (timer, bitcnt cleared); 1 -> IDLE (glitch rejected, nothing stored).
//    DATA: sample at each timer==BAUD_DIV-1 (bit centre), shift right into data reg, bitcnt++; after DATA_BITS samples -> PARITY if PARITY!=0 else STOP.
//    PARITY: one sample; err = (^data ^ pbit) for even, ~(^data ^ pbit) for odd.
//    STOP: STOP_BITS samples; any 0 sets frameErr for the word. On the cycle of the final stop sample the word+flags are written; FSM -> IDLE next cycle (no wait for end of stop bit, allows back-to-back frames).
//  - Timer width $clog2(BAUD_DIV); wraps to 0 at BAUD_DIV-1, never free-runs past it.
//  - Write latency: Receive/Dout/count update the cycle after the final stop sample.
//  - Pop: Received=1 & Receive=1 removes head; next word (or empty) visible next cycle. Received with Receive=0 is ignored.
//  - Write while full: word dropped, overrun <= 1; contents unchanged.
//  - Simultaneous write and pop when full: pop then write, no overrun, count unchanged.
//  - overrun clears only on reset; data/flags never cleared by errors.
//  - Reset_n low mid-frame: frame abandoned, all state as reset; next start bit after release is received normally.
// CONFIGURATION
//  RX_FIFO_EN defined: circular buffer of FIFO_DEPTH words {frameErr,parityErr,data}, first-word fall-through, rd/wr pointers with one extra wrap bit; count 0..FIFO_DEPTH.
//  RX_FIFO_EN undefined: single holding register; FIFO_DEPTH ignored; count is 0 or 1; full = Receive.
// TESTING
//  1. Defaults, 8N1 0x55 at 5208 clk/bit -> Receive=1 one cycle after final stop sample, Dout=0x55, flags 0, count=1; Received 1 cycle -> Receive=0 next cycle.
//  2. PARITY=1, send 0xA3 with parity bit 1 (wrong) -> Dout=0xA3, parityErr=1; repeat with parity bit 0 -> parityErr=0.
//  3. Stop bit driven 0 for 0x3C -> Dout=0x3C, frameErr=1, FSM back in IDLE, next frame 0x0F received clean.
//  4. Sin low for 1000 clk then high -> no Receive, count=0; FSM in IDLE by cycle HALF_DIV+3.
//  5. RX_FIFO_EN, FIFO_DEPTH=4: send 0x01..0x05 with no pops -> count=4, overrun=1; pops return 0x01..0x04 in order. Without RX_FIFO_EN: 0x01,0x02 -> Dout=0x01, overrun=1.
//  6. Reset_n pulsed low mid-data of 0x99 -> all outputs 0; following frame 0x66 received with Dout=0x66, flags 0.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: host-side Receive/Received handshake and word/status outputs of the UART receiver.
interface uart_rx_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                               Receive;
    logic                               Received;
    logic [DATA_BITS-1:0]               Dout;
    logic                               parityErr;
    logic                               frameErr;
    logic                               overrun;
    logic [$clog2(FIFO_DEPTH+1)-1:0]    count;

    modport master (
        output Receive, Dout, parityErr, frameErr, overrun, count,
        input  Received
    );

    modport slave (
        input  Receive, Dout, parityErr, frameErr, overrun, count,
        output Received
    );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with start-glitch rejection, per-word parity/frame flags and overrun.
// RX_FIFO_EN selects a FIFO_DEPTH-word first-word-fall-through buffer instead of a single holding register.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 19_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Sin,
    uart_rx_param_if.master  rx
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int TW       = $clog2(BAUD_DIV);
    localparam int BW       = $clog2(DATA_BITS + 1);
    localparam int CW       = $clog2(FIFO_DEPTH + 1);
    localparam int WW       = DATA_BITS + 2;
    localparam logic [TW-1:0] L_BMAX = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] L_HMAX = TW'(HALF_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 r_state;
    logic                   r_s1;
    logic                   r_srx;
    logic [TW-1:0]          r_timer;
    logic [BW-1:0]          r_bitcnt;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_overrun;

    logic                   w_tick;
    logic                   w_half;
    logic                   w_wr;
    logic [WW-1:0]          w_word;
    logic                   w_pop;
    logic                   w_avail;
    logic [WW-1:0]          w_head;
    logic [CW-1:0]          w_cnt;

    assign w_tick = (r_timer == L_BMAX);
    assign w_half = (r_timer == L_HMAX);
    // The final stop sample writes the buffer directly, so the word appears one cycle later.
    assign w_wr   = (r_state == S_STOP) && w_tick && (r_bitcnt == BW'(STOP_BITS - 1));
    assign w_word = {r_ferr | ~r_srx, r_perr, r_data};

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1     <= 1'b1;
            r_srx    <= 1'b1;
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_data   <= '0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_s1  <= Sin;
            r_srx <= r_s1;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (!r_srx) r_state <= S_START;
                end
                S_START: begin
                    if (w_half) begin
                        r_timer  <= '0;
                        r_bitcnt <= '0;
                        r_perr   <= 1'b0;
                        r_ferr   <= 1'b0;
                        r_state  <= r_srx ? S_IDLE : S_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_data  <= {r_srx, r_data[DATA_BITS-1:1]};
                        if (r_bitcnt == BW'(DATA_BITS - 1)) begin
                            r_bitcnt <= '0;
                            r_state  <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_perr  <= (PARITY == 2) ? ~(^r_data ^ r_srx) : (^r_data ^ r_srx);
                        r_state <= S_STOP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        if (!r_srx) r_ferr <= 1'b1;
                        if (r_bitcnt == BW'(STOP_BITS - 1)) begin
                            r_bitcnt <= '0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WW-1:0]  r_mem [FIFO_DEPTH];
    logic [AW:0]    r_wp;
    logic [AW:0]    r_rp;
    logic           w_empty;
    logic           w_full;
    logic           w_push;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = rx.Received & ~w_empty;
    // A pop frees the slot the same cycle, so a full buffer still accepts the word.
    assign w_push  = w_wr & (~w_full | w_pop);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_wr & w_full & ~w_pop) r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= w_word;
    end

    assign w_avail = ~w_empty;
    assign w_head  = r_mem[r_rp[AW-1:0]];
    assign w_cnt   = CW'(r_wp - r_rp);
`else
    logic           r_valid;
    logic [WW-1:0]  r_hold;

    assign w_pop = rx.Received & r_valid;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid   <= 1'b0;
            r_hold    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr & (~r_valid | w_pop)) begin
                r_hold  <= w_word;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            if (w_wr & r_valid & ~w_pop) r_overrun <= 1'b1;
        end
    end

    assign w_avail = r_valid;
    assign w_head  = r_hold;
    assign w_cnt   = CW'(r_valid);
`endif

    assign rx.Receive   = w_avail;
    assign rx.Dout      = w_avail ? w_head[DATA_BITS-1:0] : '0;
    assign rx.parityErr = w_avail & w_head[DATA_BITS];
    assign rx.frameErr  = w_avail & w_head[DATA_BITS+1];
    assign rx.overrun   = r_overrun;
    assign rx.count     = w_cnt;
endmodule
